// File: rtl/mux8_rr_scheduler_pkg.sv
// Shared types and constants for the 8-way round-robin mux scheduler.
package mux8_rr_scheduler_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam int HOLD_W = 4;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    logic [7:0] v;
    v = 8'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux8_rr_scheduler_mux8x1.sv
// Plain 8:1 single-bit mux; the scheduler is the only driver of its select.
module mux8x1 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);

  assign y = i[s];

endmodule

// File: rtl/mux8_rr_scheduler_rr_pick8.sv
// Combinational round-robin picker: first request after 'last', wrapping 7->0.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] last,
  input  logic       excl_cur,
  output logic       found,
  output logic [2:0] idx
);

  logic [7:0] masked;
  logic [2:0] cand;

  // The current owner is masked when looking for a rotation target.
  always_comb begin
    masked = req;
    if (excl_cur)
      masked[last] = 1'b0;
    found = 1'b0;
    idx   = 3'd0;
    cand  = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      cand = last + 3'(i);
      if (!found && masked[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler for a shared 8:1 mux with bounded hold time.
// Optional feature: define MUX8_SCHED_LOCK_EN to let 'lock' suppress timeout rotation.
module mux8_rr_scheduler
  import mux8_rr_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] data,
  input  logic       lock,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       y,
  output logic       y_vld
);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic [2:0]        last, last_nx, sel_nx;
  logic [7:0]        gnt_nx;
  logic              pick_found, rotate_ok, mux_out;
  logic [2:0]        pick_idx;

  rr_pick8 u_pick (
    .req      (req),
    .last     (last),
    .excl_cur (state == S_GRANT),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  mux8x1 u_mux (
    .i (data),
    .s (sel),
    .y (mux_out)
  );

`ifdef MUX8_SCHED_LOCK_EN
  assign rotate_ok = ~lock;
`else
  assign rotate_ok = ~(lock & 1'b0);
`endif

  // Once saturated, hold_cnt stays past the limit, so a late arrival still triggers rotation.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    sel_nx   = sel;
    last_nx  = last;
    hold_nx  = hold_cnt;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          gnt_nx   = onehot8(pick_idx);
          sel_nx   = pick_idx;
          last_nx  = pick_idx;
          hold_nx  = '0;
          state_nx = S_GRANT;
        end
      end
      S_GRANT: begin
        hold_nx = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        if ((!req[sel] || (hold_cnt >= HOLD_LAST && rotate_ok)) && pick_found) begin
          gnt_nx  = onehot8(pick_idx);
          sel_nx  = pick_idx;
          last_nx = pick_idx;
          hold_nx = '0;
        end else if (!req[sel]) begin
          gnt_nx   = 8'd0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= 8'd0;
      sel      <= 3'd0;
      last     <= 3'd7;
      hold_cnt <= '0;
      y        <= 1'b0;
      y_vld    <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      sel      <= sel_nx;
      last     <= last_nx;
      hold_cnt <= hold_nx;
      if (state == S_GRANT)
        y <= mux_out;
      y_vld    <= (state == S_GRANT);
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed scoreboard bench for mux8_rr_scheduler (default MAX_HOLD=4).
module tb_mux8_rr_scheduler;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
    bit         chk_y;
    logic       vld;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] data;
  logic       lock;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       y;
  logic       y_vld;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mux8_rr_scheduler #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .data  (data),
    .lock  (lock),
    .gnt   (gnt),
    .sel   (sel),
    .y     (y),
    .y_vld (y_vld)
  );

  always #5 clk = ~clk;

  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = exp_q.pop_front();
    total++;
    assert (gnt === e.gnt) else begin
      bad++;
      $error("[TB] FAIL %s.gnt observed=%h expected=%h", e.tag, gnt, e.gnt);
    end
    total++;
    assert (y_vld === e.vld) else begin
      bad++;
      $error("[TB] FAIL %s.y_vld observed=%b expected=%b", e.tag, y_vld, e.vld);
    end
    if (e.gnt != 8'd0 || e.sel != 3'd0) begin
      total++;
      assert (sel === e.sel) else begin
        bad++;
        $error("[TB] FAIL %s.sel observed=%0d expected=%0d", e.tag, sel, e.sel);
      end
    end
    if (e.chk_y) begin
      total++;
      assert (y === e.y) else begin
        bad++;
        $error("[TB] FAIL %s.y observed=%b expected=%b", e.tag, y, e.y);
      end
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic rn, input logic [7:0] r,
                                input logic [7:0] d, input logic lk,
                                input logic [7:0] eg, input logic [2:0] es,
                                input logic ey, input bit cy, input logic ev);
    exp_t e;
    rst_n = rn;
    req   = r;
    data  = d;
    lock  = lk;
    e.tag = tag; e.gnt = eg; e.sel = es; e.y = ey; e.chk_y = cy; e.vld = ev;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    rst_n = 1'b0; req = 8'hFF; data = 8'h00; lock = 1'b0;
    #1;
    $display("[TB] reset with all requests pending");
    apply_stimulus("rst0",     1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1, 1'b0);
    apply_stimulus("rst1",     1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1, 1'b0);
    apply_stimulus("first",    1'b1, 8'hFF, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0, 1, 1'b0);

    $display("[TB] two requesters rotating on timeout");
    apply_stimulus("rr_a",     1'b1, 8'h24, 8'h20, 1'b0, 8'h04, 3'd2, 1'b0, 1, 1'b1);
    apply_stimulus("rr_h1",    1'b1, 8'h24, 8'h20, 1'b0, 8'h04, 3'd2, 1'b0, 1, 1'b1);
    apply_stimulus("rr_h2",    1'b1, 8'h24, 8'h20, 1'b0, 8'h04, 3'd2, 1'b0, 1, 1'b1);
    apply_stimulus("rr_h3",    1'b1, 8'h24, 8'h20, 1'b0, 8'h04, 3'd2, 1'b0, 1, 1'b1);
    apply_stimulus("rr_to5",   1'b1, 8'h24, 8'h20, 1'b0, 8'h20, 3'd5, 1'b0, 1, 1'b1);
    apply_stimulus("rr_5h1",   1'b1, 8'h24, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1, 1'b1);
    apply_stimulus("rr_5h2",   1'b1, 8'h24, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1, 1'b1);
    apply_stimulus("rr_5h3",   1'b1, 8'h24, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1, 1'b1);
    apply_stimulus("rr_to2",   1'b1, 8'h24, 8'h20, 1'b0, 8'h04, 3'd2, 1'b1, 1, 1'b1);
    apply_stimulus("rr_2h1",   1'b1, 8'h24, 8'h20, 1'b0, 8'h04, 3'd2, 1'b0, 1, 1'b1);

    $display("[TB] lone requester 7 then wrap to 0");
    apply_stimulus("solo7",    1'b1, 8'h80, 8'h80, 1'b0, 8'h80, 3'd7, 1'b0, 1, 1'b1);
    for (int i = 0; i < 6; i++)
      apply_stimulus("solo7_hold", 1'b1, 8'h80, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1, 1'b1);
    apply_stimulus("wrap0",    1'b1, 8'h81, 8'h80, 1'b0, 8'h01, 3'd0, 1'b1, 1, 1'b1);
    apply_stimulus("wrap0_h",  1'b1, 8'h81, 8'h80, 1'b0, 8'h01, 3'd0, 1'b0, 1, 1'b1);

    $display("[TB] release handoff and drop to idle");
    apply_stimulus("gnt3",     1'b1, 8'h48, 8'h08, 1'b0, 8'h08, 3'd3, 1'b0, 1, 1'b1);
    apply_stimulus("rel6",     1'b1, 8'h40, 8'h08, 1'b0, 8'h40, 3'd6, 1'b1, 1, 1'b1);
    apply_stimulus("drop",     1'b1, 8'h00, 8'h08, 1'b0, 8'h00, 3'd6, 1'b0, 1, 1'b1);
    apply_stimulus("idle",     1'b1, 8'h00, 8'h08, 1'b0, 8'h00, 3'd6, 1'b0, 1, 1'b0);

    $display("[TB] reset in the middle of a grant");
    apply_stimulus("gnt4",     1'b1, 8'h10, 8'h10, 1'b0, 8'h10, 3'd4, 1'b0, 1, 1'b0);
    apply_stimulus("gnt4_h",   1'b1, 8'h10, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1, 1'b1);
    apply_stimulus("midrst",   1'b0, 8'h10, 8'h10, 1'b0, 8'h00, 3'd0, 1'b0, 1, 1'b0);
    apply_stimulus("last7",    1'b1, 8'hFF, 8'h10, 1'b0, 8'h01, 3'd0, 1'b0, 1, 1'b0);

    $display("[TB] lock against timeout");
    apply_stimulus("lk1",      1'b1, 8'h03, 8'h02, 1'b1, 8'h01, 3'd0, 1'b0, 0, 1'b1);
    apply_stimulus("lk2",      1'b1, 8'h03, 8'h02, 1'b1, 8'h01, 3'd0, 1'b0, 0, 1'b1);
    apply_stimulus("lk3",      1'b1, 8'h03, 8'h02, 1'b1, 8'h01, 3'd0, 1'b0, 0, 1'b1);
`ifdef MUX8_SCHED_LOCK_EN
    apply_stimulus("lk4",      1'b1, 8'h03, 8'h02, 1'b1, 8'h01, 3'd0, 1'b0, 0, 1'b1);
    apply_stimulus("lk5",      1'b1, 8'h03, 8'h02, 1'b1, 8'h01, 3'd0, 1'b0, 0, 1'b1);
`else
    apply_stimulus("lk4",      1'b1, 8'h03, 8'h02, 1'b1, 8'h02, 3'd1, 1'b0, 0, 1'b1);
    apply_stimulus("lk5",      1'b1, 8'h03, 8'h02, 1'b1, 8'h02, 3'd1, 1'b0, 0, 1'b1);
`endif
    apply_stimulus("unlock",   1'b1, 8'h03, 8'h02, 1'b0, 8'h02, 3'd1, 1'b0, 0, 1'b1);
    apply_stimulus("end_drop", 1'b1, 8'h00, 8'h02, 1'b0, 8'h00, 3'd1, 1'b1, 1, 1'b1);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
